// File: rtl/mult_shift_add_ctrl_pkg.sv
// mult_shift_add_ctrl_pkg: shared ULA constants and multiplier state encoding
package mult_shift_add_ctrl_pkg;
    localparam int WORD_W = 32;
    localparam logic [3:0] OP_MUL = 4'd2;
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/mult_shift_add_ctrl_adder.sv
// full_adder_32bit: combinational 32-bit adder with carry-out
module full_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/mult_shift_add_ctrl.sv
// mult_shift_add_ctrl: sequential 32x32->64 shift-and-add multiplier; MULT_ZERO_SKIP_EN short-circuits zero operands
module mult_shift_add_ctrl
    import mult_shift_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    if (WIDTH != WORD_W) begin : g_width_chk
        $error("mult_shift_add_ctrl: WIDTH must be 32");
    end

    mul_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mcand, mplr, addend, sum;
    logic             c, last, zero_skip;

    assign addend = mplr[0] ? mcand : '0;
    assign last   = cnt == CNT_W'(WIDTH - 1);

`ifdef MULT_ZERO_SKIP_EN
    assign zero_skip = (a == '0) || (b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    full_adder_32bit u_add (
        .a    (acc),
        .b    (addend),
        .sum  (sum),
        .cout (c)
    );

    // State register; reset aborts any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MUL_IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs; the unused encoding falls back to IDLE
    always_comb begin
        state_nx = MUL_IDLE;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            MUL_IDLE: state_nx = start ? (zero_skip ? MUL_DONE : MUL_RUN) : MUL_IDLE;
            MUL_RUN: begin
                busy     = 1'b1;
                state_nx = last ? MUL_DONE : MUL_RUN;
            end
            MUL_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: state_nx = MUL_IDLE;
        endcase
    end

    // Operand capture, one add-and-shift step per RUN cycle, product latch on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            product <= '0;
        end else if (state == MUL_IDLE && start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
            if (zero_skip) product <= '0;
        end else if (state == MUL_RUN) begin
            {acc, mplr} <= {c, sum, mplr[WIDTH-1:1]};
            cnt         <= cnt + 1'b1;
            if (last) product <= {c, sum, mplr[WIDTH-1:1]};
        end
    end
endmodule
